mix_columns_seq: RTL and testbench



---
 rtl/aes_pkg.sv | 54 +++++
 rtl/mix_single_column.sv | 45 ++++
 rtl/mix_columns_seq.sv | 95 +++++++++
 tb/tb_mix_columns_seq.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES MixColumns definitions: sizes, FSM states, column payload and GF(2^8) helpers.
// MIXCOL_INV_EN adds the InvMixColumns multipliers (9/b/d/e) to gmul.
package aes_pkg;

  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned COL_W    = 32;
  localparam int unsigned STATE_W  = NUM_COLS * COL_W;
  localparam int unsigned CNT_W    = $clog2(NUM_COLS);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } fsm_state_t;

  // One state column; a0 (row 0) sits in the MSB byte.
  typedef struct packed {
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;
  } col_t;

  // Multiply by x in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // Multiply by a small MixColumns constant; any other value passes x through (multiplier 1).
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [3:0] m);
    logic [7:0] x2;
`ifdef MIXCOL_INV_EN
    logic [7:0] x4;
    logic [7:0] x8;
`endif
    x2 = xtime(x);
`ifdef MIXCOL_INV_EN
    x4 = xtime(x2);
    x8 = xtime(x4);
`endif
    case (m)
      4'h2:    gmul = x2;
      4'h3:    gmul = x2 ^ x;
`ifdef MIXCOL_INV_EN
      4'h9:    gmul = x8 ^ x;
      4'hB:    gmul = x8 ^ x2 ^ x;
      4'hD:    gmul = x8 ^ x4 ^ x;
      4'hE:    gmul = x8 ^ x4 ^ x2;
`endif
      default: gmul = x;
    endcase
  endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational mixer for one 32-bit column (circulant GF(2^8) matrix product).
// With MIXCOL_INV_EN the inv input selects the InvMixColumns coefficients.
module mix_single_column
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
`ifdef MIXCOL_INV_EN
  input  logic             inv,
`endif
  output logic [COL_W-1:0] col_out
);

  col_t       a;
  col_t       b;
  logic [3:0] c0, c1, c2, c3;

  assign a = col_t'(col_in);

  // First row of the circulant matrix; later rows are rotations of it.
  always_comb begin
    c0 = 4'h2;
    c1 = 4'h3;
    c2 = 4'h1;
    c3 = 4'h1;
`ifdef MIXCOL_INV_EN
    if (inv) begin
      c0 = 4'hE;
      c1 = 4'hB;
      c2 = 4'hD;
      c3 = 4'h9;
    end
`endif
  end

  // Matrix-vector product, one output byte per row.
  always_comb begin
    b.a0 = gmul(a.a0, c0) ^ gmul(a.a1, c1) ^ gmul(a.a2, c2) ^ gmul(a.a3, c3);
    b.a1 = gmul(a.a0, c3) ^ gmul(a.a1, c0) ^ gmul(a.a2, c1) ^ gmul(a.a3, c2);
    b.a2 = gmul(a.a0, c2) ^ gmul(a.a1, c3) ^ gmul(a.a2, c0) ^ gmul(a.a3, c1);
    b.a3 = gmul(a.a0, c1) ^ gmul(a.a1, c2) ^ gmul(a.a2, c3) ^ gmul(a.a3, c0);
  end

  assign col_out = b;

endmodule

// File: rtl/mix_columns_seq.sv
// Column-serial AES MixColumns: one shared column mixer, four CALC cycles per state,
// result held under valid/ready. MIXCOL_INV_EN adds the inverse port and transform.
module mix_columns_seq
  import aes_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
`ifdef MIXCOL_INV_EN
  input  logic               inverse,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data,
  output logic               busy
);

  fsm_state_t                       state_q, state_d;
  logic [NUM_COLS-1:0][COL_W-1:0]   st_q;
  logic [CNT_W-1:0]                 cnt_q;
  logic [CNT_W-1:0]                 col_idx;
  logic [COL_W-1:0]                 col_mix;
`ifdef MIXCOL_INV_EN
  logic                             inv_q;
`endif

  // Column 0 lives in the top 32 bits, so counter value c addresses packed index 3-c.
  assign col_idx  = CNT_W'(NUM_COLS - 1) - cnt_q;
  assign out_data = st_q;

  mix_single_column u_mix (
    .col_in  (st_q[col_idx]),
`ifdef MIXCOL_INV_EN
    .inv     (inv_q),
`endif
    .col_out (col_mix)
  );

  // FSM state register with registered status outputs derived from the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
    end
  end

  // Next-state logic; in_ready depends on the current state only.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CALC;
      end
      CALC:    if (cnt_q == CNT_W'(NUM_COLS - 1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State capture on accept, then one column replaced per CALC cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_q  <= '0;
      cnt_q <= '0;
`ifdef MIXCOL_INV_EN
      inv_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          st_q  <= in_data;
          cnt_q <= '0;
`ifdef MIXCOL_INV_EN
          inv_q <= inverse;
`endif
        end
        CALC: begin
          st_q[col_idx] <= col_mix;
          cnt_q         <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq against a GF(2^8) matrix reference model.
// Build with MIXCOL_INV_EN to also exercise the inverse transform.
module tb_mix_columns_seq;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
`ifdef MIXCOL_INV_EN
  logic         inverse;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mix_columns_seq dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef MIXCOL_INV_EN
    .inverse   (inverse),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // Shift-and-add GF(2^8) multiply, reduction polynomial 0x11B.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = (x << 1) ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Full-state MixColumns / InvMixColumns as a circulant matrix product per column.
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit inv);
    logic [7:0]   m [4];
    logic [127:0] r;
    logic [7:0]   acc;
    if (inv) m = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
    else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc ^= gf_mul(m[(j - row + 4) % 4], s[127 - 32*c - 8*j -: 8]);
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one state and complete the input handshake (bounded wait for in_ready).
  task automatic send_block(input logic [127:0] d, input bit inv);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_in_ready got=%0b exp=1", in_ready);
    end
    in_data  = d;
    in_valid = 1'b1;
`ifdef MIXCOL_INV_EN
    inverse  = inv;
`else
    if (inv) $display("note: inverse requested without MIXCOL_INV_EN");
`endif
    tick();
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid rises, bounded.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
`ifdef MIXCOL_INV_EN
    inverse   = 1'b0;
`endif
    tick();
    tick();
    @(negedge clock);
    reset = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (out_data !== 128'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
  endtask

  task automatic test_known_vector();
    logic [127:0] exp;
    int lat;
    exp = 128'h046681e5e0cb199a48f8d37a2806264c;
    out_ready = 1'b1;
    send_block(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL known_busy got=%0b exp=1", busy); end
    wait_out(lat);
    checks++; if (lat != 4) begin failures++; $display("FAIL known_latency got=%0d exp=4", lat); end
    checks++; if (out_data !== exp) begin failures++; $display("FAIL known_data got=%h exp=%h", out_data, exp); end
    tick();
    out_ready = 1'b0;
    checks++; if ({out_valid, in_ready, busy} !== 3'b010) begin
      failures++; $display("FAIL known_release got=%b exp=010", {out_valid, in_ready, busy});
    end
  endtask

  task automatic test_column_isolation();
    logic [127:0] exp;
    int lat;
    exp = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
    send_block(128'hdb135345f20a225c01010101c6c6c6c6, 1'b0);
    wait_out(lat);
    checks++; if (out_data !== exp) begin failures++; $display("FAIL coliso_data got=%h exp=%h", out_data, exp); end
    handshake();
  endtask

  task automatic test_backpressure();
    logic [127:0] d, exp;
    int lat;
    d   = rand128();
    exp = ref_mix(d, 1'b0);
    out_ready = 1'b0;
    send_block(d, 1'b0);
    in_valid = 1'b1;
    in_data  = rand128();
    wait_out(lat);
    checks++; if (lat != 4) begin failures++; $display("FAIL bp_latency got=%0d exp=4", lat); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({out_valid, in_ready, busy} !== 3'b101 || out_data !== exp) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got=%b/%h exp=101/%h", i, {out_valid, in_ready, busy}, out_data, exp);
      end
      in_data = rand128();
      tick();
    end
    in_valid = 1'b0;
    handshake();
    checks++; if ({out_valid, in_ready, busy} !== 3'b010) begin
      failures++; $display("FAIL bp_release got=%b exp=010", {out_valid, in_ready, busy});
    end
  endtask

  task automatic test_random();
    logic [127:0] d, exp;
    bit inv;
    int lat;
    int hold;
    for (int n = 0; n < 24; n++) begin
      d = rand128();
`ifdef MIXCOL_INV_EN
      inv = bit'($urandom_range(1));
`else
      inv = 1'b0;
`endif
      exp = ref_mix(d, inv);
      send_block(d, inv);
      wait_out(lat);
      checks++; if (lat != 4) begin failures++; $display("FAIL rand_latency n=%0d got=%0d exp=4", n, lat); end
      hold = int'($urandom_range(3));
      for (int i = 0; i < hold; i++) tick();
      checks++; if (out_valid !== 1'b1 || out_data !== exp) begin
        failures++; $display("FAIL rand_data n=%0d inv=%0b got=%h exp=%h", n, inv, out_data, exp);
      end
      handshake();
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] a;
    logic [127:0] got [$];
    int acc [$];
    bit acc_now, out_now;
    a = rand128();
    in_data   = a;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      acc_now = in_valid && in_ready;
      out_now = out_valid && out_ready;
      if (out_now) got.push_back(out_data);
      tick();
      if (acc_now) begin
        acc.push_back(cyc);
        if (acc.size() == 1) in_data = '0;
        else in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++; if (acc.size() != 2) begin failures++; $display("FAIL b2b_accepts got=%0d exp=2", acc.size()); end
    else begin
      checks++; if (acc[1] - acc[0] != 6) begin failures++; $display("FAIL b2b_spacing got=%0d exp=6", acc[1] - acc[0]); end
    end
    checks++; if (got.size() != 2) begin failures++; $display("FAIL b2b_outputs got=%0d exp=2", got.size()); end
    else begin
      checks++; if (got[0] !== ref_mix(a, 1'b0)) begin failures++; $display("FAIL b2b_first got=%h exp=%h", got[0], ref_mix(a, 1'b0)); end
      checks++; if (got[1] !== 128'h0) begin failures++; $display("FAIL b2b_second got=%h exp=0", got[1]); end
    end
  endtask

  task automatic test_reset_mid_calc();
    logic [127:0] d;
    int lat;
    send_block(rand128(), 1'b0);
    tick();
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%0b exp=1", busy); end
    reset = 1'b1;
    #1;
    checks++; if ({out_valid, in_ready, busy} !== 3'b010) begin
      failures++; $display("FAIL midrst_flags got=%b exp=010", {out_valid, in_ready, busy});
    end
    checks++; if (out_data !== 128'h0) begin failures++; $display("FAIL midrst_data got=%h exp=0", out_data); end
    @(negedge clock);
    reset = 1'b0;
    tick();
    d = rand128();
    send_block(d, 1'b0);
    wait_out(lat);
    checks++; if (lat != 4 || out_data !== ref_mix(d, 1'b0)) begin
      failures++; $display("FAIL midrst_next lat=%0d got=%h exp=%h", lat, out_data, ref_mix(d, 1'b0));
    end
    handshake();
  endtask

`ifdef MIXCOL_INV_EN
  task automatic test_inverse();
    logic [127:0] exp_inv, exp_fwd;
    int lat;
    exp_inv = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    send_block(128'h046681e5e0cb199a48f8d37a2806264c, 1'b1);
    wait_out(lat);
    checks++; if (out_data !== exp_inv) begin failures++; $display("FAIL inv_data got=%h exp=%h", out_data, exp_inv); end
    handshake();
    exp_fwd = 128'h046681e5e0cb199a48f8d37a2806264c;
    send_block(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0);
    inverse = 1'b1;
    tick();
    inverse = 1'b0;
    tick();
    inverse = 1'b1;
    wait_out(lat);
    checks++; if (out_data !== exp_fwd) begin failures++; $display("FAIL inv_toggle got=%h exp=%h", out_data, exp_fwd); end
    handshake();
    inverse = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_known_vector();
    test_column_isolation();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_calc();
`ifdef MIXCOL_INV_EN
    test_inverse();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
